// File: rtl/sram_obi_retention_ctrl.sv
`timescale 1ns/1ps
// OBI-to-SRAM bridge with automatic retention entry after an idle period
// and a fixed-length wake sequence before new grants are given.
module sram_obi_retention_ctrl #(
  parameter int NumWords   = 1024,
  parameter int AddrWidth  = (NumWords <= 1) ? 1 : $clog2(NumWords),
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 obi_req_i,
  output logic                 obi_gnt_o,
  input  logic [31:0]          obi_addr_i,
  input  logic                 obi_we_i,
  input  logic [3:0]           obi_be_i,
  input  logic [31:0]          obi_wdata_i,
  output logic                 obi_rvalid_o,
  output logic [31:0]          obi_rdata_o,
  input  logic                 retention_en_i,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [3:0]           sram_be_o,
  output logic [31:0]          sram_wdata_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  input  logic [31:0]          sram_rdata_i,
  output logic                 sram_set_retentive_no,
  output logic [1:0]           ret_state_o
);

  localparam int IdleW = $clog2(IdleCycles + 1);
  localparam int WakeW = $clog2(WakeCycles + 1);
  localparam logic [IdleW-1:0] IdleMax   = IdleW'(IdleCycles);
  localparam logic [IdleW-1:0] IdleEntry = IdleW'(IdleCycles - 1);
  localparam logic [WakeW-1:0] WakeLoad  = WakeW'(WakeCycles);

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    RETENTIVE = 2'd1,
    WAKE      = 2'd2
  } ret_state_e;

  ret_state_e       state_q, state_d;
  logic [IdleW-1:0] idle_cnt_q;
  logic [WakeW-1:0] wake_cnt_q;
  logic             rvalid_q;
  logic             rd_pending_q;
  logic             cycle_idle;
  logic             unused_addr_bits;

  // A cycle with a pending response is never idle, so retention cannot cut off a read.
  assign cycle_idle = ~obi_req_i & ~rvalid_q;

  assign sram_req_o   = obi_req_i & obi_gnt_o;
  assign sram_we_o    = obi_we_i;
  assign sram_be_o    = obi_be_i;
  assign sram_wdata_o = obi_wdata_i;
  assign sram_addr_o  = obi_addr_i[AddrWidth+1:2];
  assign unused_addr_bits = ^{obi_addr_i[31:AddrWidth+2], obi_addr_i[1:0]};

  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = (rvalid_q && rd_pending_q) ? sram_rdata_i : 32'h0;
  assign ret_state_o  = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ACTIVE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE: begin
        if (retention_en_i && cycle_idle && (idle_cnt_q == IdleEntry)) begin
          state_d = RETENTIVE;
        end
      end
      RETENTIVE: begin
        if (obi_req_i || !retention_en_i) begin
          state_d = WAKE;
        end
      end
      WAKE: begin
        if (wake_cnt_q <= WakeW'(1)) begin
          state_d = ACTIVE;
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_comb begin
    obi_gnt_o             = 1'b0;
    sram_set_retentive_no = 1'b1;
    case (state_q)
      ACTIVE:    obi_gnt_o = obi_req_i;
      RETENTIVE: sram_set_retentive_no = 1'b0;
      default:   ;
    endcase
  end

  // Idle count restarts outside ACTIVE so every wake-up begins a fresh idle window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt_q <= '0;
    end else if ((state_q != ACTIVE) || !cycle_idle) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != IdleMax) begin
      idle_cnt_q <= idle_cnt_q + IdleW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wake_cnt_q <= '0;
    end else if ((state_q == RETENTIVE) && (state_d == WAKE)) begin
      wake_cnt_q <= WakeLoad;
    end else if ((state_q == WAKE) && (wake_cnt_q != '0)) begin
      wake_cnt_q <= wake_cnt_q - WakeW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q     <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      rvalid_q     <= sram_req_o;
      rd_pending_q <= sram_req_o & ~obi_we_i;
    end
  end

endmodule
